// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM stage: FSM encoding, MEM/WB control
// bundle and its bubble value, and the misalignment helper.
package mem_access_stage_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef struct packed {
    logic reg_write;
    logic memto_reg;
    logic halt;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_BUBBLE = '0;

  // Word accesses only: any nonzero byte offset on a memory op is an error.
  function automatic logic is_misaligned(input logic mem_op, input logic [1:0] addr_lo);
    return mem_op && (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage: registered request side plus the
// memory's read data and one-cycle completion pulse.
interface mem_access_stage_if
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register: loads a full instruction slot or a bubble; the
// error flags only live for the single slot they were loaded with.
module mem_wb_reg
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_inputs,
  input  logic              load_bubble,
  input  wb_ctrl_t          ctrl_in,
  input  logic              align_err_in,
  input  logic              bus_err_in,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [4:0]        write_reg_in,
  output wb_ctrl_t          ctrl_out,
  output logic              align_err_out,
  output logic              bus_err_out,
  output logic [DATA_W-1:0] read_data_out,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [4:0]        write_reg_out
);

  wb_ctrl_t          ctrl_q, ctrl_d;
  logic              align_err_q, align_err_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [4:0]        write_reg_q, write_reg_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    ctrl_d       = ctrl_q;
    align_err_d  = 1'b0;
    bus_err_d    = 1'b0;
    read_data_d  = read_data_q;
    alu_result_d = alu_result_q;
    write_reg_d  = write_reg_q;
    if (load_inputs) begin
      ctrl_d       = ctrl_in;
      align_err_d  = align_err_in;
      bus_err_d    = bus_err_in;
      read_data_d  = read_data_in;
      alu_result_d = alu_result_in;
      write_reg_d  = write_reg_in;
    end else if (load_bubble) begin
      // Bubbles kill the control bits but leave the data fields alone.
      ctrl_d = WB_BUBBLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q       <= WB_BUBBLE;
      align_err_q  <= 1'b0;
      bus_err_q    <= 1'b0;
      read_data_q  <= '0;
      alu_result_q <= '0;
      write_reg_q  <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      align_err_q  <= align_err_d;
      bus_err_q    <= bus_err_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      write_reg_q  <= write_reg_d;
    end
  end

  assign ctrl_out       = ctrl_q;
  assign align_err_out  = align_err_q;
  assign bus_err_out    = bus_err_q;
  assign read_data_out  = read_data_q;
  assign alu_result_out = alu_result_q;
  assign write_reg_out  = write_reg_q;

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: issues loads/stores on a req/ack memory port, stalls the
// front of the pipe while an access is outstanding and owns MEM/WB.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                RegWriteIn,
  input  logic                MemtoRegIn,
  input  logic                MemWriteIn,
  input  logic [DATA_W-1:0]   ALUResultIn,
  input  logic [4:0]          WriteRegIn,
  input  logic [DATA_W-1:0]   WriteDataIn,
  input  logic                HaltIn,
  mem_access_stage_if.master  mem,
  output logic                StallOut,
  output logic                RegWriteOut,
  output logic                MemtoRegOut,
  output logic [DATA_W-1:0]   ReadDataOut,
  output logic [DATA_W-1:0]   ALUResultOut,
  output logic [4:0]          WriteRegOut,
  output logic                HaltOut,
  output logic                AlignErrOut,
  output logic                BusErrOut
);

  localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              mem_op, misaligned, timeout_hit;
  logic              stall, load_inputs, load_bubble, align_err, bus_err;
  logic [DATA_W-1:0] read_data;
  wb_ctrl_t          wb_ctrl_in, wb_ctrl_out;

  assign mem_op      = MemtoRegIn | MemWriteIn;
  assign misaligned  = is_misaligned(mem_op, ALUResultIn[1:0]);
  assign timeout_hit = TIMEOUT_EN && (state_q == ACCESS) && !mem.mem_ack && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    stall       = 1'b0;
    load_inputs = 1'b0;
    load_bubble = 1'b0;
    align_err   = 1'b0;
    bus_err     = 1'b0;
    read_data   = '0;
    // A load+store combination is treated as a store, so it never writes back memory data.
    wb_ctrl_in  = '{reg_write: RegWriteIn, memto_reg: MemtoRegIn & ~MemWriteIn, halt: HaltIn};

    case (state_q)
      IDLE: begin
        if (mem_op && !misaligned) begin
          stall       = 1'b1;
          req_d       = 1'b1;
          we_d        = MemWriteIn;
          addr_d      = ALUResultIn;
          wdata_d     = WriteDataIn;
          cnt_d       = '0;
          state_d     = ACCESS;
          load_bubble = 1'b1;
        end else begin
          load_inputs = 1'b1;
          if (misaligned) begin
            wb_ctrl_in.reg_write = 1'b0;
            align_err            = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (mem.mem_ack) begin
          req_d       = 1'b0;
          state_d     = IDLE;
          load_inputs = 1'b1;
          read_data   = MemWriteIn ? '0 : mem.mem_rdata;
        end else if (timeout_hit) begin
          req_d                = 1'b0;
          state_d              = IDLE;
          load_inputs          = 1'b1;
          wb_ctrl_in.reg_write = 1'b0;
          bus_err              = 1'b1;
        end else begin
          stall       = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
          load_bubble = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign StallOut      = stall;

  mem_wb_reg #(.DATA_W(DATA_W)) u_mem_wb (
    .clk            (clk),
    .reset          (reset),
    .load_inputs    (load_inputs),
    .load_bubble    (load_bubble),
    .ctrl_in        (wb_ctrl_in),
    .align_err_in   (align_err),
    .bus_err_in     (bus_err),
    .read_data_in   (read_data),
    .alu_result_in  (ALUResultIn),
    .write_reg_in   (WriteRegIn),
    .ctrl_out       (wb_ctrl_out),
    .align_err_out  (AlignErrOut),
    .bus_err_out    (BusErrOut),
    .read_data_out  (ReadDataOut),
    .alu_result_out (ALUResultOut),
    .write_reg_out  (WriteRegOut)
  );

  assign RegWriteOut = wb_ctrl_out.reg_write;
  assign MemtoRegOut = wb_ctrl_out.memto_reg;
  assign HaltOut     = wb_ctrl_out.halt;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, load/store with
// varying ack delay, misalignment, bus timeout and reset mid-access.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteIn, MemtoRegIn, MemWriteIn, HaltIn;
  logic [31:0] ALUResultIn, WriteDataIn;
  logic [4:0]  WriteRegIn;
  logic        StallOut, RegWriteOut, MemtoRegOut, HaltOut, AlignErrOut, BusErrOut;
  logic [31:0] ReadDataOut, ALUResultOut;
  logic [4:0]  WriteRegOut;

  int n_checks = 0;
  int n_fail   = 0;
  int stalls, req_cycles;

  mem_access_stage_if #(.DATA_W(32)) bus ();

  mem_access_stage #(.DATA_W(32), .TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .RegWriteIn   (RegWriteIn),
    .MemtoRegIn   (MemtoRegIn),
    .MemWriteIn   (MemWriteIn),
    .ALUResultIn  (ALUResultIn),
    .WriteRegIn   (WriteRegIn),
    .WriteDataIn  (WriteDataIn),
    .HaltIn       (HaltIn),
    .mem          (bus.master),
    .StallOut     (StallOut),
    .RegWriteOut  (RegWriteOut),
    .MemtoRegOut  (MemtoRegOut),
    .ReadDataOut  (ReadDataOut),
    .ALUResultOut (ALUResultOut),
    .WriteRegOut  (WriteRegOut),
    .HaltOut      (HaltOut),
    .AlignErrOut  (AlignErrOut),
    .BusErrOut    (BusErrOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic mw, input logic [31:0] alu,
                       input logic [4:0] wr, input logic [31:0] wd, input logic halt);
    RegWriteIn  = rw;
    MemtoRegIn  = m2r;
    MemWriteIn  = mw;
    ALUResultIn = alu;
    WriteRegIn  = wr;
    WriteDataIn = wd;
    HaltIn      = halt;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0, 1'b0);
  endtask

  // Inputs already hold an aligned mem op; k=0 is the IDLE issue cycle and
  // ack is pulsed in ACCESS cycle ack_cycle. Returns just after the ack edge.
  task automatic run_access(input int ack_cycle, input logic [31:0] exp_addr, input logic exp_we,
                            input logic [31:0] exp_wdata, output int n_stall);
    n_stall = 0;
    for (int k = 0; k < 64; k++) begin
      bus.mem_ack = (k == ack_cycle + 1);
      #1;
      if (StallOut) n_stall++;
      if (k >= 1) begin
        check($sformatf("req_held_k%0d", k), 32'(bus.mem_req), 32'd1);
        check($sformatf("addr_k%0d", k), bus.mem_addr, exp_addr);
        check($sformatf("we_k%0d", k), 32'(bus.mem_we), 32'(exp_we));
        check($sformatf("wdata_k%0d", k), bus.mem_wdata, exp_wdata);
        check($sformatf("bubble_rw_k%0d", k), 32'(RegWriteOut), 32'd0);
        check($sformatf("bubble_halt_k%0d", k), 32'(HaltOut), 32'd0);
      end
      tick();
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        return;
      end
    end
    check("access_budget", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    idle_inputs();
    tick();
    tick();
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_rw", 32'(RegWriteOut), 32'd0);
    check("rst_alu", ALUResultOut, 32'd0);
    check("rst_align", 32'(AlignErrOut), 32'd0);
    check("rst_buserr", 32'(BusErrOut), 32'd0);
    reset = 1'b0;

    // ALU op passes straight through in one cycle
    drive(1'b1, 1'b0, 1'b0, 32'h0000_002A, 5'd5, 32'h0, 1'b0);
    #1;
    check("alu_stall", 32'(StallOut), 32'd0);
    tick();
    check("alu_rw", 32'(RegWriteOut), 32'd1);
    check("alu_res", ALUResultOut, 32'h2A);
    check("alu_wreg", 32'(WriteRegOut), 32'd5);
    check("alu_rdata", ReadDataOut, 32'd0);
    check("alu_req", 32'(bus.mem_req), 32'd0);

    // Load, ack in the 4th ACCESS cycle
    bus.mem_rdata = 32'hDEAD_BEEF;
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0100, 5'd7, 32'h0, 1'b0);
    run_access(3, 32'h100, 1'b0, 32'h0, stalls);
    check("ld_stalls", 32'(stalls), 32'd4);
    check("ld_req_drop", 32'(bus.mem_req), 32'd0);
    check("ld_rw", 32'(RegWriteOut), 32'd1);
    check("ld_m2r", 32'(MemtoRegOut), 32'd1);
    check("ld_rdata", ReadDataOut, 32'hDEAD_BEEF);
    check("ld_wreg", 32'(WriteRegOut), 32'd7);
    check("ld_alu", ALUResultOut, 32'h100);

    // Store with ack in the first ACCESS cycle; halt rides along
    bus.mem_rdata = 32'hFFFF_FFFF;
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0204, 5'd0, 32'h0000_1234, 1'b1);
    run_access(0, 32'h204, 1'b1, 32'h1234, stalls);
    check("st_stalls", 32'(stalls), 32'd1);
    check("st_rdata", ReadDataOut, 32'd0);
    check("st_m2r", 32'(MemtoRegOut), 32'd0);
    check("st_halt", 32'(HaltOut), 32'd1);
    check("st_req_drop", 32'(bus.mem_req), 32'd0);
    idle_inputs();
    tick();
    check("st_halt_gone", 32'(HaltOut), 32'd0);

    // Misaligned load: no request, one-slot alignment error
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0103, 5'd9, 32'h0, 1'b0);
    #1;
    check("mis_stall", 32'(StallOut), 32'd0);
    tick();
    check("mis_req", 32'(bus.mem_req), 32'd0);
    check("mis_align", 32'(AlignErrOut), 32'd1);
    check("mis_rw", 32'(RegWriteOut), 32'd0);
    check("mis_alu", ALUResultOut, 32'h103);
    idle_inputs();
    tick();
    check("mis_align_clr", 32'(AlignErrOut), 32'd0);

    // Timeout: no ack ever arrives
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0300, 5'd11, 32'h0, 1'b0);
    stalls     = 0;
    req_cycles = 0;
    for (int k = 0; k < 64; k++) begin
      #1;
      if (StallOut) stalls++;
      tick();
      if (bus.mem_req) req_cycles++;
      else break;
    end
    check("to_req_cycles", 32'(req_cycles), 32'd16);
    check("to_stalls", 32'(stalls), 32'd16);
    check("to_buserr", 32'(BusErrOut), 32'd1);
    check("to_rw", 32'(RegWriteOut), 32'd0);
    check("to_alu", ALUResultOut, 32'h300);
    idle_inputs();
    tick();
    check("to_buserr_clr", 32'(BusErrOut), 32'd0);

    // Reset in the second ACCESS cycle, then a stray ack
    drive(1'b1, 1'b0, 1'b0, 32'h0000_0055, 5'd3, 32'h0, 1'b0);
    tick();
    check("pre_alu", ALUResultOut, 32'h55);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0400, 5'd4, 32'h0, 1'b0);
    tick();
    tick();
    check("pre_rst_req", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    check("mid_rst_req", 32'(bus.mem_req), 32'd0);
    check("mid_rst_addr", bus.mem_addr, 32'd0);
    check("mid_rst_alu", ALUResultOut, 32'd0);
    check("mid_rst_wreg", 32'(WriteRegOut), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    #1;
    check("stray_stall", 32'(StallOut), 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    check("stray_rw", 32'(RegWriteOut), 32'd0);
    check("stray_m2r", 32'(MemtoRegOut), 32'd0);
    check("stray_rdata", ReadDataOut, 32'd0);
    check("stray_req", 32'(bus.mem_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
